// File: rtl/wb_slot_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// wb_slot_arbiter_pkg
// Shared definitions for the Wishbone slot arbiter and its helpers:
//   - arbiter state encoding
//   - slot base constants for the slaves on the core's register bus
//   - default error data value and a saturating counter helper
// No ports (package).
// -----------------------------------------------------------------------------
package wb_slot_arbiter_pkg;

    // Arbiter states. The explicit encoding keeps state values stable
    // for anyone probing the state register on a logic analyser.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ACTIVE  = 3'd1,
        ST_RESP    = 3'd2,
        ST_ERR     = 3'd3,
        ST_RELEASE = 3'd4
    } arb_state_e;

    // Slot numbers (upper address nibble) of the slaves on the default bus.
    localparam logic [3:0] CH1_BASE    = 4'h0;
    localparam logic [3:0] CH2_BASE    = 4'h1;
    localparam logic [3:0] CH3_BASE    = 4'h2;
    localparam logic [3:0] CH4_BASE    = 4'h3;
    localparam logic [3:0] CH5_BASE    = 4'h4;
    localparam logic [3:0] CH6_BASE    = 4'h5;
    localparam logic [3:0] CH7_BASE    = 4'h6;
    localparam logic [3:0] CH8_BASE    = 4'h7;
    localparam logic [3:0] GLITCH_BASE = 4'h8;
    localparam logic [3:0] CLKA_BASE   = 4'h9;
    localparam logic [3:0] CLKB_BASE   = 4'hA;
    localparam logic [3:0] CLKD_BASE   = 4'hB;

    // Value returned to the master alongside an error pulse.
    localparam logic [7:0] ERR_DATA_DEFAULT = 8'hFF;

    // Increment that sticks at 255 instead of wrapping to 0.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/wb_slot_arbiter_bus_timer.sv
// -----------------------------------------------------------------------------
// bus_timer
// Counts cycles a slave access has been outstanding and flags the last
// allowed cycle.
// Ports:
//   clk_i      system clock
//   rst_i      synchronous active-high reset
//   clr_i      clear count to 0 (wins over en_i)
//   en_i       advance count by one
//   expired_o  count has reached TIMEOUT-1
// -----------------------------------------------------------------------------
module bus_timer
    import wb_slot_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [TW-1:0] cnt_q;
    logic [TW-1:0] cnt_d;

    // Next count: clear has priority so the count always starts at 0
    // when an access begins.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + TW'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == TW'(TIMEOUT - 1));

endmodule

// File: rtl/wb_slot_arbiter.sv
// -----------------------------------------------------------------------------
// wb_slot_arbiter
// Decodes the upper address bits of a master access into a slave slot,
// strobes only that slave, registers the returned data/ack and reports
// unmapped slots or slave timeouts as a one-cycle bus error. A held
// master strobe is only serviced once; it must drop before the next access.
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   stb_i, we_i    master strobe (held until ack_o/err_o) and write enable
//   adr_i, dat_i   master address and write data
//   dat_o          registered read data (ERR_DATA on error)
//   ack_o, err_o   one-cycle completion / error pulses
//   s_stb_o        one-hot slave strobes
//   s_we_o, s_adr_o, s_dat_o   latched write enable, low address, write data
//   s_dat_i        flattened slave read data, slot k at [k*DW +: DW]
//   s_ack_i        slave acks
//   err_cnt_o      saturating error count
//   err_adr_o      address of the most recent error
// -----------------------------------------------------------------------------
module wb_slot_arbiter
    import wb_slot_arbiter_pkg::*;
#(
    parameter int            AW       = 8,
    parameter int            DW       = 8,
    parameter int            SW       = 4,
    parameter int            NSLV     = 12,
    parameter int            TIMEOUT  = 16,
    parameter logic [DW-1:0] ERR_DATA = DW'(ERR_DATA_DEFAULT)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 stb_i,
    input  logic                 we_i,
    input  logic [AW-1:0]        adr_i,
    input  logic [DW-1:0]        dat_i,
    output logic [DW-1:0]        dat_o,
    output logic                 ack_o,
    output logic                 err_o,
    output logic [NSLV-1:0]      s_stb_o,
    output logic                 s_we_o,
    output logic [AW-SW-1:0]     s_adr_o,
    output logic [DW-1:0]        s_dat_o,
    input  logic [NSLV*DW-1:0]   s_dat_i,
    input  logic [NSLV-1:0]      s_ack_i,
    output logic [7:0]           err_cnt_o,
    output logic [AW-1:0]        err_adr_o
);

    arb_state_e      state_q,   state_d;
    logic [AW-1:0]   adr_q,     adr_d;
    logic            we_q,      we_d;
    logic [DW-1:0]   wdat_q,    wdat_d;
    logic [DW-1:0]   rdat_q,    rdat_d;
    logic [NSLV-1:0] stb_q,     stb_d;
    logic            ack_q,     ack_d;
    logic            err_q,     err_d;
    logic [7:0]      err_cnt_q, err_cnt_d;
    logic [AW-1:0]   err_adr_q, err_adr_d;

    logic            timer_clr;
    logic            timer_en;
    logic            timer_expired;
    logic            enter_err;

    logic [SW-1:0]   req_slot;
    logic [SW-1:0]   cur_slot;
    logic            req_mapped;
    logic [NSLV-1:0] req_onehot;
    logic            sel_ack;
    logic [DW-1:0]   sel_dat;

    assign req_slot = adr_i[AW-1 -: SW];
    assign cur_slot = adr_q[AW-1 -: SW];

    // Request decode: a slot is mapped only if a slave exists for it, which
    // also yields the one-hot strobe pattern for that slave.
    always_comb begin
        req_mapped = 1'b0;
        req_onehot = '0;
        for (int k = 0; k < NSLV; k++) begin
            if (int'(req_slot) == k) begin
                req_mapped    = 1'b1;
                req_onehot[k] = 1'b1;
            end
        end
    end

    // Response mux: only the ack and data of the slave being accessed are
    // looked at, so stray acks from other slaves cannot complete an access.
    always_comb begin
        sel_ack = 1'b0;
        sel_dat = '0;
        for (int k = 0; k < NSLV; k++) begin
            if (int'(cur_slot) == k) begin
                sel_ack = s_ack_i[k];
                sel_dat = s_dat_i[k*DW +: DW];
            end
        end
    end

    bus_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clr_i     (timer_clr),
        .en_i      (timer_en),
        .expired_o (timer_expired)
    );

    // Next-state and output logic. ack/err are registered on the transition
    // into RESP/ERR so they are high exactly while the FSM sits in those
    // one-cycle states. An ack on the last timer cycle still completes the
    // access because it is checked before the expiry flag.
    always_comb begin
        state_d   = state_q;
        adr_d     = adr_q;
        we_d      = we_q;
        wdat_d    = wdat_q;
        rdat_d    = rdat_q;
        stb_d     = stb_q;
        ack_d     = 1'b0;
        err_d     = 1'b0;
        err_cnt_d = err_cnt_q;
        err_adr_d = err_adr_q;
        timer_clr = 1'b1;
        timer_en  = 1'b0;
        enter_err = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (stb_i) begin
                    adr_d  = adr_i;
                    we_d   = we_i;
                    wdat_d = dat_i;
                    if (req_mapped) begin
                        stb_d   = req_onehot;
                        state_d = ST_ACTIVE;
                    end else begin
                        enter_err = 1'b1;
                    end
                end
            end
            ST_ACTIVE: begin
                timer_clr = 1'b0;
                timer_en  = 1'b1;
                if (sel_ack) begin
                    rdat_d  = sel_dat;
                    stb_d   = '0;
                    ack_d   = 1'b1;
                    state_d = ST_RESP;
                end else if (timer_expired) begin
                    stb_d     = '0;
                    enter_err = 1'b1;
                end
            end
            ST_RESP: begin
                state_d = ST_RELEASE;
            end
            ST_ERR: begin
                state_d = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (!stb_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                stb_d   = '0;
                state_d = ST_IDLE;
            end
        endcase

        // adr_d already holds the address of the failing access, whether it
        // was captured this cycle (unmapped) or earlier (timeout).
        if (enter_err) begin
            state_d   = ST_ERR;
            err_d     = 1'b1;
            rdat_d    = ERR_DATA;
            err_adr_d = adr_d;
            err_cnt_d = sat_inc8(err_cnt_q);
        end
    end

    // State and datapath registers; reset aborts any access in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            adr_q     <= '0;
            we_q      <= 1'b0;
            wdat_q    <= '0;
            rdat_q    <= '0;
            stb_q     <= '0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
            err_adr_q <= '0;
        end else begin
            state_q   <= state_d;
            adr_q     <= adr_d;
            we_q      <= we_d;
            wdat_q    <= wdat_d;
            rdat_q    <= rdat_d;
            stb_q     <= stb_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
            err_adr_q <= err_adr_d;
        end
    end

    assign dat_o     = rdat_q;
    assign ack_o     = ack_q;
    assign err_o     = err_q;
    assign s_stb_o   = stb_q;
    assign s_we_o    = we_q;
    assign s_adr_o   = adr_q[AW-SW-1:0];
    assign s_dat_o   = wdat_q;
    assign err_cnt_o = err_cnt_q;
    assign err_adr_o = err_adr_q;

endmodule

// File: tb/tb_wb_slot_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_slot_arbiter
// Self-checking bench for wb_slot_arbiter. A behavioural slave answers after
// a chosen number of strobe cycles; expected results come from a
// transaction-level model of the slot map, timeout and error counter.
// -----------------------------------------------------------------------------
module tb_wb_slot_arbiter;

    localparam int AW      = 8;
    localparam int DW      = 8;
    localparam int SW      = 4;
    localparam int NSLV    = 12;
    localparam int TIMEOUT = 16;

    logic                 clk;
    logic                 rst;
    logic                 stb;
    logic                 we;
    logic [AW-1:0]        adr;
    logic [DW-1:0]        wdat;
    logic [DW-1:0]        dat_o;
    logic                 ack_o;
    logic                 err_o;
    logic [NSLV-1:0]      s_stb_o;
    logic                 s_we_o;
    logic [AW-SW-1:0]     s_adr_o;
    logic [DW-1:0]        s_dat_o;
    logic [NSLV*DW-1:0]   sDat;
    logic [NSLV-1:0]      sAck;
    logic [7:0]           err_cnt_o;
    logic [AW-1:0]        err_adr_o;

    int nChecks = 0;
    int nPass   = 0;

    // Transaction-level model state.
    int         modelErrCnt;
    logic [7:0] modelErrAdr;
    logic [7:0] modelDat;

    typedef struct {
        logic [NSLV-1:0] stbUnion;
        int              stbCycles;
        int              doneCycle;
        logic            gotAck;
        logic            gotErr;
        logic [7:0]      datAtDone;
        logic [7:0]      errCnt;
        logic [7:0]      errAdr;
        logic            weLat;
        logic [3:0]      adrLat;
        logic [7:0]      sdatLat;
        logic [NSLV-1:0] holdStb;
        int              holdPulses;
        logic [7:0]      datAfterHold;
    } obs_t;

    wb_slot_arbiter #(
        .AW       (AW),
        .DW       (DW),
        .SW       (SW),
        .NSLV     (NSLV),
        .TIMEOUT  (TIMEOUT),
        .ERR_DATA (8'hFF)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .stb_i     (stb),
        .we_i      (we),
        .adr_i     (adr),
        .dat_i     (wdat),
        .dat_o     (dat_o),
        .ack_o     (ack_o),
        .err_o     (err_o),
        .s_stb_o   (s_stb_o),
        .s_we_o    (s_we_o),
        .s_adr_o   (s_adr_o),
        .s_dat_o   (s_dat_o),
        .s_dat_i   (sDat),
        .s_ack_i   (sAck),
        .err_cnt_o (err_cnt_o),
        .err_adr_o (err_adr_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net in case some wait escapes its bound.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference model: what one master access should produce, from the slot
    // map (slots >= NSLV unmapped), the slave's ack delay (0 = never) and the
    // timeout rule (ack on or before the TIMEOUT-th strobe cycle wins).
    task automatic predict(input logic [7:0] a, input int ackDelay, input logic [7:0] slaveData,
                           output logic expAck, output int expStbCycles, output logic [NSLV-1:0] expStb);
        int slot;
        slot = int'(a[7:4]);
        if (slot >= NSLV) begin
            expAck       = 1'b0;
            expStbCycles = 0;
            expStb       = '0;
        end else begin
            expStb = NSLV'(1) << slot;
            if (ackDelay >= 1 && ackDelay <= TIMEOUT) begin
                expAck       = 1'b1;
                expStbCycles = ackDelay;
            end else begin
                expAck       = 1'b0;
                expStbCycles = TIMEOUT;
            end
        end
        if (expAck) begin
            modelDat = slaveData;
        end else begin
            modelDat    = 8'hFF;
            modelErrAdr = a;
            if (modelErrCnt < 255) modelErrCnt++;
        end
    endtask

    // Drives one access and records what the DUT did; no judgement here.
    // The slave acks once it has seen its strobe for ackDelay cycles.
    // After completion the strobe stays high holdCycles more cycles, then
    // drops for one cycle before returning.
    task automatic applyStimulus(input logic [7:0] a, input logic w, input logic [7:0] d,
                                 input int ackDelay, input logic [7:0] slaveData,
                                 input logic [NSLV-1:0] noise, input int holdCycles,
                                 output obs_t o);
        int slot;
        logic [NSLV-1:0] sel;
        slot = int'(a[7:4]);
        sel  = (slot < NSLV) ? (NSLV'(1) << slot) : '0;
        o.stbUnion = '0; o.stbCycles = 0; o.doneCycle = 0; o.gotAck = 1'b0; o.gotErr = 1'b0;
        o.datAtDone = '0; o.errCnt = '0; o.errAdr = '0; o.weLat = 1'b0; o.adrLat = '0;
        o.sdatLat = '0; o.holdStb = '0; o.holdPulses = 0; o.datAfterHold = '0;

        @(negedge clk);
        for (int k = 0; k < NSLV; k++) sDat[k*DW +: DW] = 8'($urandom);
        if (slot < NSLV) sDat[slot*DW +: DW] = slaveData;
        sAck = noise & ~sel;
        stb  = 1'b1;
        we   = w;
        adr  = a;
        wdat = d;

        for (int c = 0; c < TIMEOUT + 6 && !(o.gotAck || o.gotErr); c++) begin
            @(negedge clk);
            if (c == 0) begin
                o.weLat   = s_we_o;
                o.adrLat  = s_adr_o;
                o.sdatLat = s_dat_o;
            end
            o.stbUnion |= s_stb_o;
            if (ack_o || err_o) begin
                o.gotAck    = ack_o;
                o.gotErr    = err_o;
                o.doneCycle = c + 1;
                o.datAtDone = dat_o;
                o.errCnt    = err_cnt_o;
                o.errAdr    = err_adr_o;
            end else begin
                if (s_stb_o != '0) o.stbCycles++;
                if (ackDelay > 0 && o.stbCycles == ackDelay) sAck = sAck | sel;
            end
        end
        sAck = '0;

        for (int h = 0; h < holdCycles; h++) begin
            @(negedge clk);
            o.holdStb |= s_stb_o;
            if (ack_o || err_o) o.holdPulses++;
        end
        @(negedge clk);
        o.holdStb |= s_stb_o;
        if (ack_o || err_o) o.holdPulses++;
        o.datAfterHold = dat_o;
        stb = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; stb = 1'b0; we = 1'b0; adr = '0; wdat = '0; sDat = '0; sAck = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        nChecks++; if (dat_o !== 8'h00)     $display("[TB] FAIL reset_dat: got %h expected 00", dat_o); else nPass++;
        nChecks++; if (s_stb_o !== '0)      $display("[TB] FAIL reset_stb: got %h expected 000", s_stb_o); else nPass++;
        nChecks++; if ({ack_o, err_o, s_we_o} !== 3'b000) $display("[TB] FAIL reset_flags: got %b expected 000", {ack_o, err_o, s_we_o}); else nPass++;
        nChecks++; if ({s_adr_o, s_dat_o} !== 12'h000) $display("[TB] FAIL reset_slave_bus: got %h expected 000", {s_adr_o, s_dat_o}); else nPass++;
        nChecks++; if ({err_cnt_o, err_adr_o} !== 16'h0000) $display("[TB] FAIL reset_err_regs: got %h expected 0000", {err_cnt_o, err_adr_o}); else nPass++;
        rst = 1'b0;
        modelErrCnt = 0; modelErrAdr = 8'h00; modelDat = 8'h00;
    endtask

    task automatic test_read_slot3();
        obs_t o; logic expAck; int expCyc; logic [NSLV-1:0] expStb;
        applyStimulus(8'h35, 1'b0, 8'h00, 2, 8'hA5, NSLV'($urandom), 0, o);
        predict(8'h35, 2, 8'hA5, expAck, expCyc, expStb);
        nChecks++; if (o.stbUnion !== 12'h008) $display("[TB] FAIL read3_stb: got %h expected 008", o.stbUnion); else nPass++;
        nChecks++; if (o.adrLat !== 4'h5)      $display("[TB] FAIL read3_sadr: got %h expected 5", o.adrLat); else nPass++;
        nChecks++; if (o.stbCycles !== expCyc) $display("[TB] FAIL read3_stbcycles: got %0d expected %0d", o.stbCycles, expCyc); else nPass++;
        nChecks++; if (o.gotAck !== 1'b1 || o.gotErr !== 1'b0) $display("[TB] FAIL read3_ack: got ack=%b err=%b expected ack=1 err=0", o.gotAck, o.gotErr); else nPass++;
        nChecks++; if (o.doneCycle !== expCyc + 1) $display("[TB] FAIL read3_latency: got %0d expected %0d", o.doneCycle, expCyc + 1); else nPass++;
        nChecks++; if (o.datAtDone !== 8'hA5)  $display("[TB] FAIL read3_dat: got %h expected a5", o.datAtDone); else nPass++;
        nChecks++; if (o.holdPulses !== 0)     $display("[TB] FAIL read3_single_pulse: got %0d extra expected 0", o.holdPulses); else nPass++;
    endtask

    task automatic test_write_noise();
        obs_t o; logic expAck; int expCyc; logic [NSLV-1:0] expStb;
        applyStimulus(8'h72, 1'b1, 8'h3C, 3, 8'h5A, '1, 1, o);
        predict(8'h72, 3, 8'h5A, expAck, expCyc, expStb);
        nChecks++; if (o.stbUnion !== 12'h080) $display("[TB] FAIL write_stb: got %h expected 080", o.stbUnion); else nPass++;
        nChecks++; if (o.weLat !== 1'b1)       $display("[TB] FAIL write_we: got %b expected 1", o.weLat); else nPass++;
        nChecks++; if (o.sdatLat !== 8'h3C)    $display("[TB] FAIL write_sdat: got %h expected 3c", o.sdatLat); else nPass++;
        nChecks++; if (o.stbCycles !== expCyc) $display("[TB] FAIL write_noise_ignored: got %0d strobe cycles expected %0d", o.stbCycles, expCyc); else nPass++;
        nChecks++; if (o.gotAck !== 1'b1 || o.holdPulses !== 0) $display("[TB] FAIL write_ack: got ack=%b extra=%0d expected ack=1 extra=0", o.gotAck, o.holdPulses); else nPass++;
    endtask

    task automatic test_unmapped();
        obs_t o; logic expAck; int expCyc; logic [NSLV-1:0] expStb;
        applyStimulus(8'hE0, 1'b0, 8'h00, 1, 8'h11, NSLV'($urandom), 0, o);
        predict(8'hE0, 1, 8'h11, expAck, expCyc, expStb);
        nChecks++; if (o.stbUnion !== '0)       $display("[TB] FAIL unmapped_stb: got %h expected 000", o.stbUnion); else nPass++;
        nChecks++; if (o.gotErr !== 1'b1 || o.gotAck !== 1'b0) $display("[TB] FAIL unmapped_err: got err=%b ack=%b expected err=1 ack=0", o.gotErr, o.gotAck); else nPass++;
        nChecks++; if (o.doneCycle !== 1)       $display("[TB] FAIL unmapped_latency: got %0d expected 1", o.doneCycle); else nPass++;
        nChecks++; if (o.datAtDone !== 8'hFF)   $display("[TB] FAIL unmapped_dat: got %h expected ff", o.datAtDone); else nPass++;
        nChecks++; if (o.errAdr !== 8'hE0)      $display("[TB] FAIL unmapped_erradr: got %h expected e0", o.errAdr); else nPass++;
        nChecks++; if (o.errCnt !== 8'(modelErrCnt)) $display("[TB] FAIL unmapped_errcnt: got %0d expected %0d", o.errCnt, modelErrCnt); else nPass++;
    endtask

    task automatic test_timeout();
        obs_t o; logic expAck; int expCyc; logic [NSLV-1:0] expStb;
        applyStimulus(8'h4C, 1'b0, 8'h00, 0, 8'h22, '0, 0, o);
        predict(8'h4C, 0, 8'h22, expAck, expCyc, expStb);
        nChecks++; if (o.stbCycles !== TIMEOUT) $display("[TB] FAIL timeout_stbcycles: got %0d expected %0d", o.stbCycles, TIMEOUT); else nPass++;
        nChecks++; if (o.gotErr !== 1'b1 || o.doneCycle !== TIMEOUT + 1) $display("[TB] FAIL timeout_err: got err=%b at %0d expected err=1 at %0d", o.gotErr, o.doneCycle, TIMEOUT + 1); else nPass++;
        nChecks++; if (o.errCnt !== 8'(modelErrCnt) || o.errAdr !== modelErrAdr) $display("[TB] FAIL timeout_errregs: got %0d/%h expected %0d/%h", o.errCnt, o.errAdr, modelErrCnt, modelErrAdr); else nPass++;
    endtask

    task automatic test_ack_at_expiry();
        obs_t o; logic expAck; int expCyc; logic [NSLV-1:0] expStb;
        applyStimulus(8'hB7, 1'b0, 8'h00, TIMEOUT, 8'h6E, '0, 0, o);
        predict(8'hB7, TIMEOUT, 8'h6E, expAck, expCyc, expStb);
        nChecks++; if (o.gotAck !== expAck || o.gotErr !== 1'b0) $display("[TB] FAIL expiry_ack_wins: got ack=%b err=%b expected ack=%b err=0", o.gotAck, o.gotErr, expAck); else nPass++;
        nChecks++; if (o.datAtDone !== modelDat) $display("[TB] FAIL expiry_dat: got %h expected %h", o.datAtDone, modelDat); else nPass++;
        nChecks++; if (o.errCnt !== 8'(modelErrCnt)) $display("[TB] FAIL expiry_errcnt: got %0d expected %0d", o.errCnt, modelErrCnt); else nPass++;
    endtask

    task automatic test_back_to_back();
        obs_t o; logic expAck; int expCyc; logic [NSLV-1:0] expStb;
        applyStimulus(8'h1F, 1'b0, 8'h00, 1, 8'hC3, '0, 10, o);
        predict(8'h1F, 1, 8'hC3, expAck, expCyc, expStb);
        nChecks++; if (o.stbCycles !== 1 || o.stbUnion !== expStb) $display("[TB] FAIL b2b_one_strobe: got %0d cycles %h expected 1 cycle %h", o.stbCycles, o.stbUnion, expStb); else nPass++;
        nChecks++; if (o.holdStb !== '0 || o.holdPulses !== 0) $display("[TB] FAIL b2b_no_retrigger: got stb=%h pulses=%0d expected 000/0", o.holdStb, o.holdPulses); else nPass++;
        nChecks++; if (o.datAfterHold !== 8'hC3) $display("[TB] FAIL b2b_dat_hold: got %h expected c3", o.datAfterHold); else nPass++;
        applyStimulus(8'h94, 1'b1, 8'h77, 2, 8'h3D, '0, 0, o);
        predict(8'h94, 2, 8'h3D, expAck, expCyc, expStb);
        nChecks++; if (o.gotAck !== 1'b1 || o.doneCycle !== 3) $display("[TB] FAIL b2b_second_access: got ack=%b at %0d expected ack=1 at 3", o.gotAck, o.doneCycle); else nPass++;
        nChecks++; if (o.stbUnion !== expStb || o.datAtDone !== 8'h3D) $display("[TB] FAIL b2b_second_data: got %h/%h expected %h/3d", o.stbUnion, o.datAtDone, expStb); else nPass++;
    endtask

    task automatic test_random();
        obs_t o; logic expAck; int expCyc; logic [NSLV-1:0] expStb;
        logic [7:0] a; logic w; logic [7:0] d; logic [7:0] sd; int dly; int hold;
        for (int i = 0; i < 40; i++) begin
            a    = 8'($urandom);
            w    = 1'($urandom);
            d    = 8'($urandom);
            sd   = 8'($urandom);
            dly  = $urandom_range(0, TIMEOUT + 2);
            hold = $urandom_range(0, 3);
            applyStimulus(a, w, d, dly, sd, NSLV'($urandom), hold, o);
            predict(a, dly, sd, expAck, expCyc, expStb);
            nChecks++; if (o.gotAck !== expAck || o.gotErr !== !expAck) $display("[TB] FAIL rnd_result adr=%h dly=%0d: got ack=%b err=%b expected ack=%b", a, dly, o.gotAck, o.gotErr, expAck); else nPass++;
            nChecks++; if (o.stbUnion !== expStb || o.stbCycles !== expCyc) $display("[TB] FAIL rnd_strobe adr=%h: got %h x%0d expected %h x%0d", a, o.stbUnion, o.stbCycles, expStb, expCyc); else nPass++;
            nChecks++; if (o.doneCycle !== expCyc + 1) $display("[TB] FAIL rnd_latency adr=%h: got %0d expected %0d", a, o.doneCycle, expCyc + 1); else nPass++;
            nChecks++; if (o.datAtDone !== modelDat || o.datAfterHold !== modelDat) $display("[TB] FAIL rnd_dat adr=%h: got %h/%h expected %h", a, o.datAtDone, o.datAfterHold, modelDat); else nPass++;
            nChecks++; if (o.errCnt !== 8'(modelErrCnt) || o.errAdr !== modelErrAdr) $display("[TB] FAIL rnd_errregs adr=%h: got %0d/%h expected %0d/%h", a, o.errCnt, o.errAdr, modelErrCnt, modelErrAdr); else nPass++;
            nChecks++; if (o.weLat !== w || o.adrLat !== a[3:0] || o.sdatLat !== d) $display("[TB] FAIL rnd_latch adr=%h: got %b/%h/%h expected %b/%h/%h", a, o.weLat, o.adrLat, o.sdatLat, w, a[3:0], d); else nPass++;
            nChecks++; if (o.holdStb !== '0 || o.holdPulses !== 0) $display("[TB] FAIL rnd_hold adr=%h: got %h/%0d expected 000/0", a, o.holdStb, o.holdPulses); else nPass++;
        end
    endtask

    task automatic test_reset_mid_access();
        int pulses;
        @(negedge clk);
        sAck = '0; stb = 1'b1; we = 1'b1; adr = 8'h26; wdat = 8'h99;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        stb = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        modelErrCnt = 0; modelErrAdr = 8'h00; modelDat = 8'h00;
        nChecks++; if (s_stb_o !== '0 || ack_o !== 1'b0 || err_o !== 1'b0) $display("[TB] FAIL midrst_outputs: got stb=%h ack=%b err=%b expected 000/0/0", s_stb_o, ack_o, err_o); else nPass++;
        nChecks++; if ({dat_o, s_we_o, s_adr_o, s_dat_o, err_cnt_o, err_adr_o} !== '0) $display("[TB] FAIL midrst_regs: got %h expected 0", {dat_o, s_we_o, s_adr_o, s_dat_o, err_cnt_o, err_adr_o}); else nPass++;
        pulses = 0;
        repeat (TIMEOUT + 4) begin
            @(negedge clk);
            if (ack_o || err_o || s_stb_o != '0) pulses++;
        end
        nChecks++; if (pulses !== 0) $display("[TB] FAIL midrst_aborted: got %0d active cycles expected 0", pulses); else nPass++;
    endtask

    task automatic test_saturation();
        obs_t o; logic expAck; int expCyc; logic [NSLV-1:0] expStb;
        logic [7:0] a; int dly; int ok;
        ok = 1;
        for (int i = 0; i < 300; i++) begin
            if (i % 10 == 0) begin
                a   = {4'($urandom_range(0, NSLV - 1)), 4'($urandom)};
                dly = 0;
            end else begin
                a   = {4'($urandom_range(NSLV, 15)), 4'($urandom)};
                dly = 1;
            end
            applyStimulus(a, 1'b0, 8'h00, dly, 8'h00, '0, 0, o);
            predict(a, dly, 8'h00, expAck, expCyc, expStb);
            if (o.gotErr !== 1'b1 || o.errCnt !== 8'(modelErrCnt)) ok = 0;
        end
        nChecks++; if (ok !== 1) $display("[TB] FAIL sat_each_error: an error access reported a count other than the model's"); else nPass++;
        nChecks++; if (err_cnt_o !== 8'd255) $display("[TB] FAIL sat_errcnt: got %0d expected 255", err_cnt_o); else nPass++;
        nChecks++; if (err_adr_o !== modelErrAdr) $display("[TB] FAIL sat_erradr: got %h expected %h", err_adr_o, modelErrAdr); else nPass++;
    endtask

    initial begin
        test_reset();
        test_read_slot3();
        test_write_noise();
        test_unmapped();
        test_timeout();
        test_ack_at_expiry();
        test_back_to_back();
        test_random();
        test_reset_mid_access();
        test_saturation();
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
